// File: rtl/cheshire_reg_mailbox.sv
// cheshire_reg_mailbox: regbus TX/RX word-stream mailbox (clk_i, rst_i, reg_req_i/reg_rsp_o, in_*/out_* streams, irq_o), optional IRQCFG via CHESHIRE_MBOX_IRQ_EN
package cheshire_pkg;
  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_a48_d32_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_a48_d32_rsp_t;
endpackage

module cheshire_reg_mailbox #(
  parameter int unsigned Depth = 8,
  parameter type reg_req_t = cheshire_pkg::reg_a48_d32_req_t,
  parameter type reg_rsp_t = cheshire_pkg::reg_a48_d32_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  reg_req_t    reg_req_i,
  output reg_rsp_t    reg_rsp_o,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        irq_o
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;
  typedef enum logic {IDLE, RESP} state_e;
  state_e state_q, state_d;
  logic [31:0] tx_mem [Depth];
  logic [31:0] rx_mem [Depth];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [LW-1:0] tx_lvl, rx_lvl;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic [31:0] rdata_q, rdata_d, status, cfg_rd;
  logic err_q, err_d, push_q, push_d, pop_q, pop_d, cfg_q, cfg_d, flush_q, flush_d;
  logic commit, tx_in, tx_out, rx_in, rx_out, flush;
  logic unused_addr;
  assign unused_addr = ^reg_req_i.addr[47:12];
  assign tx_empty = tx_lvl == '0;
  assign rx_empty = rx_lvl == '0;
  assign tx_full = tx_lvl == LW'(Depth);
  assign rx_full = rx_lvl == LW'(Depth);
  assign status = {8'h0, 8'(tx_lvl), 8'(rx_lvl), 4'h0, tx_full, tx_empty, rx_full, rx_empty};
  assign commit = state_q == RESP;
  assign tx_in = commit && push_q;
  assign rx_out = commit && pop_q;
  assign flush = commit && flush_q;
  assign in_ready_o = !rx_full;
  assign out_valid_o = !tx_empty;
  assign out_data_o = tx_empty ? '0 : tx_mem[tx_rp];
  assign rx_in = in_valid_i && in_ready_o;
  assign tx_out = out_valid_o && out_ready_i;
  assign reg_rsp_o.rdata = rdata_q;
  assign reg_rsp_o.error = err_q;
  assign reg_rsp_o.ready = commit;
  always_comb begin
    state_d = commit ? IDLE : state_q;
    rdata_d = rdata_q;
    err_d = err_q;
    push_d = 1'b0;
    pop_d = 1'b0;
    cfg_d = 1'b0;
    flush_d = 1'b0;
    if (!commit && reg_req_i.valid) begin
      state_d = RESP;
      rdata_d = '0;
      err_d = 1'b0;
      case (reg_req_i.addr[11:0])
        12'h000: begin
          err_d = !reg_req_i.write || tx_full || reg_req_i.wstrb != 4'hf;
          push_d = reg_req_i.write && !tx_full && reg_req_i.wstrb == 4'hf;
        end
        12'h004: begin
          err_d = reg_req_i.write || rx_empty;
          pop_d = !reg_req_i.write && !rx_empty;
          rdata_d = (!reg_req_i.write && !rx_empty) ? rx_mem[rx_rp] : '0;
        end
        12'h008: begin
          err_d = reg_req_i.write;
          rdata_d = reg_req_i.write ? '0 : status;
        end
        12'h00c: begin
          cfg_d = reg_req_i.write;
          rdata_d = reg_req_i.write ? '0 : cfg_rd;
        end
        12'h010: flush_d = reg_req_i.write && reg_req_i.wdata[0] && reg_req_i.wstrb[0];
        default: err_d = 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q <= 1'b0;
      push_q <= 1'b0;
      pop_q <= 1'b0;
      cfg_q <= 1'b0;
      flush_q <= 1'b0;
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
      tx_lvl <= '0;
      rx_lvl <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      push_q <= push_d;
      pop_q <= pop_d;
      cfg_q <= cfg_d;
      flush_q <= flush_d;
      if (flush) begin
        tx_wp <= '0;
        tx_rp <= '0;
        rx_wp <= '0;
        rx_rp <= '0;
        tx_lvl <= '0;
        rx_lvl <= '0;
      end else begin
        if (tx_in) begin
          tx_mem[tx_wp] <= reg_req_i.wdata;
          tx_wp <= tx_wp + 1'b1;
        end
        if (tx_out) tx_rp <= tx_rp + 1'b1;
        tx_lvl <= tx_lvl + LW'(tx_in) - LW'(tx_out);
        if (rx_in) begin
          rx_mem[rx_wp] <= in_data_i;
          rx_wp <= rx_wp + 1'b1;
        end
        if (rx_out) rx_rp <= rx_rp + 1'b1;
        rx_lvl <= rx_lvl + LW'(rx_in) - LW'(rx_out);
      end
    end
  end
`ifdef CHESHIRE_MBOX_IRQ_EN
  logic en_q, irq_q;
  logic [7:0] thr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q <= 1'b0;
      thr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (commit && cfg_q && reg_req_i.wstrb[0]) en_q <= reg_req_i.wdata[0];
      if (commit && cfg_q && reg_req_i.wstrb[1]) thr_q <= reg_req_i.wdata[15:8];
      irq_q <= en_q && 8'(rx_lvl) >= (thr_q == 8'd0 ? 8'd1 : thr_q);
    end
  end
  assign cfg_rd = {16'h0, thr_q, 7'h0, en_q};
  assign irq_o = irq_q;
`else
  logic unused_cfg;
  assign unused_cfg = cfg_q;
  assign cfg_rd = '0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_cheshire_reg_mailbox.sv
// tb_cheshire_reg_mailbox: table, directed and random checks of cheshire_reg_mailbox against a queue model
module tb_cheshire_reg_mailbox;
  import cheshire_pkg::*;
  localparam int D = 8;
  localparam int NONE = 0, TXP = 1, RXP = 2, CFG = 3, FLUSH = 4;
`ifdef CHESHIRE_MBOX_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif
  typedef struct packed {
    logic [11:0] a;
    logic        w;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] rd;
    logic        er;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  reg_a48_d32_req_t req;
  reg_a48_d32_rsp_t rsp;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, irq;
  logic [31:0] in_data = '0, out_data;
  int checks = 0, errors = 0;
  logic [31:0] rx_q[$], tx_q[$];
  logic en_m = 1'b0, irq_m = 1'b0;
  logic [7:0] thr_m = '0;
  bit rnd = 1'b0;
  always #5 clk = ~clk;
  cheshire_reg_mailbox #(.Depth(D)) dut (
    .clk_i(clk), .rst_i(rst), .reg_req_i(req), .reg_rsp_o(rsp),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .irq_o(irq)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] status_m();
    return {8'h0, 8'(tx_q.size()), 8'(rx_q.size()), 4'h0,
            tx_q.size() == D, tx_q.size() == 0, rx_q.size() == D, rx_q.size() == 0};
  endfunction
  task automatic step(input int op, input logic [31:0] wd, input logic [3:0] st);
    logic hi, ho, nirq;
    if (rnd) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      out_ready = 1'($urandom_range(0, 1));
    end
    chk("in_ready", in_ready, rx_q.size() < D);
    chk("out_valid", out_valid, tx_q.size() != 0);
    chk("out_data", out_data, tx_q.size() != 0 ? tx_q[0] : 32'h0);
    chk("irq", irq, irq_m);
    hi = in_valid && rx_q.size() < D;
    ho = out_ready && tx_q.size() != 0;
    nirq = en_m && rx_q.size() >= ((thr_m == 8'd0) ? 1 : int'(thr_m));
    @(posedge clk);
    irq_m = nirq;
    if (op == FLUSH) begin
      rx_q.delete();
      tx_q.delete();
    end else begin
      if (ho) void'(tx_q.pop_front());
      if (op == TXP) tx_q.push_back(wd);
      if (op == RXP) void'(rx_q.pop_front());
      if (hi) rx_q.push_back(in_data);
    end
    if (op == CFG && IRQ_IMPL) begin
      if (st[0]) en_m = wd[0];
      if (st[1]) thr_m = wd[15:8];
    end
    @(negedge clk);
  endtask
  task automatic acc(input logic [11:0] a, input logic w, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output logic er);
    int op = NONE;
    logic [31:0] erd = '0;
    logic eer = 1'b0;
    case (a)
      12'h000: if (!w || st != 4'hf || tx_q.size() == D) eer = 1'b1; else op = TXP;
      12'h004: if (w || rx_q.size() == 0) eer = 1'b1; else begin op = RXP; erd = rx_q[0]; end
      12'h008: if (w) eer = 1'b1; else erd = status_m();
      12'h00c: if (IRQ_IMPL) begin if (w) op = CFG; else erd = {16'h0, thr_m, 7'h0, en_m}; end
      12'h010: if (w && wd[0] && st[0]) op = FLUSH;
      default: eer = 1'b1;
    endcase
    chk("ready_pre", rsp.ready, 0);
    req = '{addr: {36'h0, a}, write: w, wdata: wd, wstrb: st, valid: 1'b1};
    step(NONE, wd, st);
    chk("ready", rsp.ready, 1);
    chk($sformatf("rdata@%h", a), rsp.rdata, erd);
    chk($sformatf("error@%h", a), rsp.error, eer);
    rd = rsp.rdata;
    er = rsp.error;
    req.valid = 1'b0;
    step(op, wd, st);
  endtask
  task automatic push_in(input logic [31:0] d);
    in_valid = 1'b1;
    in_data = d;
    step(NONE, '0, '0);
    in_valid = 1'b0;
  endtask
  initial begin
    vec_t tbl[15];
    logic [31:0] rd;
    logic er;
    tbl[0]  = '{12'h008, 1'b0, 32'h0,      4'h0, 32'h5,     1'b0};
    tbl[1]  = '{12'h000, 1'b0, 32'h0,      4'h0, 32'h0,     1'b1};
    tbl[2]  = '{12'h004, 1'b0, 32'h0,      4'h0, 32'h0,     1'b1};
    tbl[3]  = '{12'h008, 1'b1, 32'hffff,   4'hf, 32'h0,     1'b1};
    tbl[4]  = '{12'h004, 1'b1, 32'h1234,   4'hf, 32'h0,     1'b1};
    tbl[5]  = '{12'h014, 1'b0, 32'h0,      4'h0, 32'h0,     1'b1};
    tbl[6]  = '{12'h014, 1'b1, 32'h1,      4'hf, 32'h0,     1'b1};
    tbl[7]  = '{12'h002, 1'b0, 32'h0,      4'h0, 32'h0,     1'b1};
    tbl[8]  = '{12'h000, 1'b1, 32'hdead,   4'h3, 32'h0,     1'b1};
    tbl[9]  = '{12'h00c, 1'b0, 32'h0,      4'h0, 32'h0,     1'b0};
    tbl[10] = '{12'h010, 1'b0, 32'h0,      4'h0, 32'h0,     1'b0};
    tbl[11] = '{12'h000, 1'b1, 32'h11,     4'hf, 32'h0,     1'b0};
    tbl[12] = '{12'h008, 1'b0, 32'h0,      4'h0, 32'h10001, 1'b0};
    tbl[13] = '{12'h010, 1'b1, 32'h1,      4'hf, 32'h0,     1'b0};
    tbl[14] = '{12'h008, 1'b0, 32'h0,      4'h0, 32'h5,     1'b0};
    req = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rsp.ready, 0);
    chk("rst_error", rsp.error, 0);
    chk("rst_rdata", rsp.rdata, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_irq", irq, 0);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      acc(tbl[i].a, tbl[i].w, tbl[i].wd, tbl[i].st, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_error", i), er, tbl[i].er);
    end
    push_in(32'ha1);
    push_in(32'hb2);
    push_in(32'hc3);
    acc(12'h008, 1'b0, '0, '0, rd, er);
    chk("rx_level3", rd[15:8], 3);
    acc(12'h004, 1'b0, '0, '0, rd, er);
    chk("rx_a1", rd, 32'ha1);
    acc(12'h004, 1'b0, '0, '0, rd, er);
    chk("rx_b2", rd, 32'hb2);
    acc(12'h004, 1'b0, '0, '0, rd, er);
    chk("rx_c3", rd, 32'hc3);
    chk("rx_c3_err", er, 0);
    acc(12'h004, 1'b0, '0, '0, rd, er);
    chk("rx_empty_rd", rd, 0);
    chk("rx_empty_err", er, 1);
    for (int i = 0; i < D; i++) begin
      acc(12'h000, 1'b1, 32'h100 + i, 4'hf, rd, er);
      chk("tx_fill_err", er, 0);
    end
    acc(12'h008, 1'b0, '0, '0, rd, er);
    chk("tx_full", rd[3], 1);
    chk("tx_level8", rd[23:16], D);
    acc(12'h000, 1'b1, 32'h999, 4'hf, rd, er);
    chk("tx_overflow_err", er, 1);
    out_ready = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("tx_stream_valid", out_valid, 1);
      chk("tx_stream_data", out_data, 32'h100 + i);
      step(NONE, '0, '0);
    end
    chk("tx_drained", out_valid, 0);
    out_ready = 1'b0;
    acc(12'h00c, 1'b1, 32'h201, 4'hf, rd, er);
    chk("irqcfg_wr_err", er, 0);
    acc(12'h00c, 1'b0, '0, '0, rd, er);
    chk("irqcfg_rd", rd, IRQ_IMPL ? 32'h201 : 32'h0);
    push_in(32'h1);
    step(NONE, '0, '0);
    chk("irq_one_word", irq, 0);
    push_in(32'h2);
    chk("irq_lag", irq, 0);
    step(NONE, '0, '0);
    chk("irq_two_words", irq, IRQ_IMPL);
    acc(12'h004, 1'b0, '0, '0, rd, er);
    step(NONE, '0, '0);
    chk("irq_after_pop", irq, 0);
    acc(12'h004, 1'b0, '0, '0, rd, er);
    for (int i = 0; i < D; i++) push_in(32'h200 + i);
    chk("rx_full_in_ready", in_ready, 0);
    push_in(32'hbad);
    acc(12'h004, 1'b0, '0, '0, rd, er);
    chk("rx_full_pop", rd, 32'h200);
    chk("rx_pop_in_ready", in_ready, 1);
    req = '{addr: 48'h4, write: 1'b0, wdata: '0, wstrb: '0, valid: 1'b1};
    step(NONE, '0, '0);
    chk("pp_ready", rsp.ready, 1);
    chk("pp_rdata", rsp.rdata, 32'h201);
    req.valid = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h2ff;
    step(RXP, '0, '0);
    in_valid = 1'b0;
    acc(12'h008, 1'b0, '0, '0, rd, er);
    chk("pp_level", rd[15:8], 7);
    for (int i = 0; i < 7; i++) acc(12'h004, 1'b0, '0, '0, rd, er);
    chk("pp_tail", rd, 32'h2ff);
    for (int i = 0; i < 4; i++) push_in(32'h300 + i);
    for (int i = 0; i < 4; i++) acc(12'h000, 1'b1, 32'h400 + i, 4'hf, rd, er);
    acc(12'h008, 1'b0, '0, '0, rd, er);
    chk("pre_flush", rd[23:8], 16'h0404);
    req = '{addr: 48'h10, write: 1'b1, wdata: 32'h1, wstrb: 4'hf, valid: 1'b1};
    step(NONE, 32'h1, 4'hf);
    chk("flush_ready", rsp.ready, 1);
    req.valid = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h3ff;
    out_ready = 1'b1;
    step(FLUSH, 32'h1, 4'hf);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    acc(12'h008, 1'b0, '0, '0, rd, er);
    chk("flush_status", rd, 32'h5);
    rnd = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [11:0] offs [6] = '{12'h000, 12'h004, 12'h008, 12'h00c, 12'h010, 12'h014};
      logic [3:0] st;
      st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      acc(offs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), $urandom, st, rd, er);
    end
    rnd = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    push_in(32'h55);
    req = '{addr: 48'h0, write: 1'b1, wdata: 32'h66, wstrb: 4'hf, valid: 1'b1};
    step(NONE, '0, '0);
    chk("rst_mid_ready", rsp.ready, 1);
    rst = 1'b1;
    req.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rx_q.delete();
    tx_q.delete();
    en_m = 1'b0;
    thr_m = '0;
    irq_m = 1'b0;
    chk("mid_ready", rsp.ready, 0);
    chk("mid_error", rsp.error, 0);
    chk("mid_rdata", rsp.rdata, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_out_data", out_data, 0);
    chk("mid_irq", irq, 0);
    rst = 1'b0;
    step(NONE, '0, '0);
    chk("mid_no_ready", rsp.ready, 0);
    acc(12'h008, 1'b0, '0, '0, rd, er);
    chk("mid_status", rd, 32'h5);
    acc(12'h00c, 1'b0, '0, '0, rd, er);
    chk("mid_irqcfg", rd, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
